unary_sweep_checker: RTL and testbench

- Self-checking stimulus/response engine for the unary-operator test module.
- Sweeps every value of a SIZE-bit input, drives it to the device under test, samples the N-bit and 1-bit results, and compares them against internally computed expected values.
- Sits in the systest bench around the unary-operator module, one instance per tested width. Reports pass/fail, error count and first failing vector.

---
 rtl/unary_test_pkg.sv | 28 ++
 rtl/unary_expect.sv | 31 +++
 rtl/unary_sweep_checker.sv | 114 +++++++++++
 tb/tb_unary_sweep_checker.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/unary_test_pkg.sv
// Shared definitions for the unary-operator sweep checker: FSM states and
// bit positions of the reduction-result bus and the sticky failure mask.
package unary_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam int RED_W      = 8;
  localparam int RED_LOGNOT = 0;
  localparam int RED_AND    = 1;
  localparam int RED_NAND   = 2;
  localparam int RED_OR     = 3;
  localparam int RED_NOR    = 4;
  localparam int RED_XOR    = 5;
  localparam int RED_XNOR   = 6;
  localparam int RED_XNOR2  = 7;

  localparam int FM_BITNOT = 0;
  localparam int FM_PLUS   = 1;
  localparam int FM_MINUS  = 2;
  localparam int FM_RED0   = 3;
  localparam int FM_W      = FM_RED0 + RED_W;

endpackage

// File: rtl/unary_expect.sv
// Golden model of the unary-operator device: stimulus in, expected results out.
module unary_expect
  import unary_test_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0]  stim,
  output logic [SIZE-1:0]  exp_bitnot,
  output logic [SIZE-1:0]  exp_plus,
  output logic [SIZE-1:0]  exp_minus,
  output logic [RED_W-1:0] exp_red
);

  assign exp_bitnot = ~stim;
  assign exp_plus   = stim;
  // Two's-complement negate wraps to (2^SIZE - stim) mod 2^SIZE.
  assign exp_minus  = (~stim) + 1'b1;

  always_comb begin
    exp_red             = '0;
    exp_red[RED_LOGNOT] = (stim == '0);
    exp_red[RED_AND]    = &stim;
    exp_red[RED_NAND]   = ~&stim;
    exp_red[RED_OR]     = |stim;
    exp_red[RED_NOR]    = ~|stim;
    exp_red[RED_XOR]    = ^stim;
    exp_red[RED_XNOR]   = ~^stim;
    exp_red[RED_XNOR2]  = ~^stim;
  end

endmodule

// File: rtl/unary_sweep_checker.sv
// Sweeps every SIZE-bit stimulus through the unary-operator device, two cycles
// per vector (settle, then check), and accumulates error statistics.
module unary_sweep_checker
  import unary_test_pkg::*;
#(
  parameter int SIZE = 4,
  parameter int ERRW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [SIZE-1:0]  stim,
  input  logic [SIZE-1:0]  resp_bitnot,
  input  logic [SIZE-1:0]  resp_plus,
  input  logic [SIZE-1:0]  resp_minus,
  input  logic [RED_W-1:0] resp_red,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERRW-1:0]  err_count,
  output logic [SIZE-1:0]  first_fail,
  output logic [FM_W-1:0]  fail_mask
);

  localparam logic [SIZE-1:0] STIM_LAST = '1;
  localparam logic [ERRW-1:0] ERR_MAX   = '1;

  state_e           state;
  logic             ff_seen;
  logic [SIZE-1:0]  exp_bitnot, exp_plus, exp_minus;
  logic [RED_W-1:0] exp_red;
  logic [FM_W-1:0]  fails;
  logic             any_fail;
  logic [ERRW-1:0]  err_next;

  unary_expect #(.SIZE(SIZE)) u_expect (
    .stim       (stim),
    .exp_bitnot (exp_bitnot),
    .exp_plus   (exp_plus),
    .exp_minus  (exp_minus),
    .exp_red    (exp_red)
  );

  // Case inequality so X/Z on a response bit reads as a mismatch in simulation.
  always_comb begin
    fails            = '0;
    fails[FM_BITNOT] = (resp_bitnot !== exp_bitnot);
    fails[FM_PLUS]   = (resp_plus   !== exp_plus);
    fails[FM_MINUS]  = (resp_minus  !== exp_minus);
    for (int i = 0; i < RED_W; i++)
      fails[FM_RED0+i] = (resp_red[i] !== exp_red[i]);
    any_fail = |fails;
    err_next = err_count;
    if (any_fail && (err_count != ERR_MAX))
      err_next = err_count + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      stim       <= '0;
      err_count  <= '0;
      first_fail <= '0;
      fail_mask  <= '0;
      ff_seen    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else if (abort) begin
      // Partial counters survive an abort for post-mortem inspection.
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_DRIVE;
            stim       <= '0;
            err_count  <= '0;
            first_fail <= '0;
            fail_mask  <= '0;
            ff_seen    <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
          end
        end
        ST_DRIVE: state <= ST_CHECK;
        ST_CHECK: begin
          fail_mask <= fail_mask | fails;
          err_count <= err_next;
          if (any_fail && !ff_seen) begin
            first_fail <= stim;
            ff_seen    <= 1'b1;
          end
          if (stim == STIM_LAST) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            stim  <= stim + 1'b1;
            state <= ST_DRIVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unary_sweep_checker.sv
// Scoreboard bench: a fault-injectable device model feeds the main checker,
// an always-wrong device feeds an ERRW=3 copy, and a correct device a SIZE=1 copy.
module tb_unary_sweep_checker;
  import unary_test_pkg::*;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  always #5 clk = ~clk;

  // Main instance (SIZE=4, ERRW=8)
  logic [3:0]  stim, resp_bitnot, resp_plus, resp_minus, first_fail;
  logic [7:0]  resp_red, err_count;
  logic [10:0] fail_mask;
  logic        busy, done, pass;
  // Saturation instance (SIZE=4, ERRW=3)
  logic [3:0]  s_stim, s_first;
  logic [2:0]  s_err;
  logic [10:0] s_mask;
  logic        s_busy, s_done, s_pass;
  logic [19:0] s_word;
  // Single-bit instance (SIZE=1)
  logic [0:0]  o_stim, o_bitnot, o_plus, o_minus, o_first;
  logic [7:0]  o_red, o_err;
  logic [10:0] o_mask;
  logic        o_busy, o_done, o_pass;

  // Reference behaviour straight from the operator definitions
  function automatic int r_bitnot(int v, int s); return ((1 << s) - 1) - v; endfunction
  function automatic int r_minus(int v, int s); return ((1 << s) - v) % (1 << s); endfunction
  function automatic logic [7:0] r_red(int v, int s);
    logic [7:0] r;
    int ones = (1 << s) - 1;
    bit odd  = ($countones(v) % 2) == 1;
    r[0] = (v == 0); r[1] = (v == ones); r[2] = (v != ones); r[3] = (v != 0);
    r[4] = (v == 0); r[5] = odd; r[6] = !odd; r[7] = !odd;
    return r;
  endfunction
  // {red[7:0], minus, plus, bitnot} of a correct 4-bit device
  function automatic logic [19:0] r_pack(int v);
    return {r_red(v, 4), 4'(r_minus(v, 4)), 4'(v), 4'(r_bitnot(v, 4))};
  endfunction

  // Faulty device: correct response XOR a per-vector flip pattern
  logic [19:0] flip [16];
  logic [19:0] dev_word;
  always_comb dev_word = r_pack(int'(stim)) ^ flip[stim];
  assign resp_bitnot = dev_word[3:0];
  assign resp_plus   = dev_word[7:4];
  assign resp_minus  = dev_word[11:8];
  assign resp_red    = dev_word[19:12];

  always_comb s_word = ~r_pack(int'(s_stim));

  assign o_bitnot = 1'(r_bitnot(int'(o_stim), 1));
  assign o_plus   = o_stim;
  assign o_minus  = 1'(r_minus(int'(o_stim), 1));
  assign o_red    = r_red(int'(o_stim), 1);

  unary_sweep_checker #(.SIZE(4), .ERRW(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stim(stim),
    .resp_bitnot(resp_bitnot), .resp_plus(resp_plus), .resp_minus(resp_minus),
    .resp_red(resp_red), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail), .fail_mask(fail_mask));

  unary_sweep_checker #(.SIZE(4), .ERRW(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stim(s_stim),
    .resp_bitnot(s_word[3:0]), .resp_plus(s_word[7:4]), .resp_minus(s_word[11:8]),
    .resp_red(s_word[19:12]), .busy(s_busy), .done(s_done), .pass(s_pass),
    .err_count(s_err), .first_fail(s_first), .fail_mask(s_mask));

  unary_sweep_checker #(.SIZE(1), .ERRW(8)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stim(o_stim),
    .resp_bitnot(o_bitnot), .resp_plus(o_plus), .resp_minus(o_minus),
    .resp_red(o_red), .busy(o_busy), .done(o_done), .pass(o_pass),
    .err_count(o_err), .first_fail(o_first), .fail_mask(o_mask));

  typedef struct {
    int          err;
    int          first;
    logic [10:0] mask;
    int          pass;
  } exp_t;

  exp_t  sbq[$];
  exp_t  e;
  int    total = 0, bad = 0, ndone = 0;
  longint start_t = 0;
  logic  done_q = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Whole-sweep expectation for the main instance from the flip table
  function automatic exp_t model(int errw);
    exp_t r;
    bit seen = 0;
    r.err = 0; r.first = 0; r.mask = '0;
    for (int v = 0; v < 16; v++) begin
      logic [19:0] f = flip[v];
      if (f != 0) begin
        if (r.err < (1 << errw) - 1) r.err++;
        if (!seen) begin r.first = v; seen = 1; end
      end
      if (|f[3:0])  r.mask[0] = 1'b1;
      if (|f[7:4])  r.mask[1] = 1'b1;
      if (|f[11:8]) r.mask[2] = 1'b1;
      for (int j = 0; j < 8; j++) if (f[12+j]) r.mask[3+j] = 1'b1;
    end
    r.pass = (r.err == 0);
    return r;
  endfunction

  task automatic set_flips(input int mode);
    for (int v = 0; v < 16; v++) begin
      case (mode)
        1:       flip[v] = 20'h1 << 17;                  // xor output inverted
        2:       flip[v] = (v % 2 == 1) ? 20'h1 : 20'h0; // bitnot bit0 stuck at 1
        3:       flip[v] = ($urandom_range(0, 3) == 0) ? (20'h1 << $urandom_range(0, 19)) : 20'h0;
        4:       flip[v] = ($urandom_range(0, 1) == 0) ? 20'($urandom) : 20'h0;
        default: flip[v] = 20'h0;
      endcase
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); start_t = $time;
    #1 start = 1'b0;
  endtask

  // restart_at > 0 re-pulses start at that cycle of the sweep; it must be ignored
  task automatic run_sweep(input int restart_at);
    int n0 = ndone;
    sbq.push_back(model(8));
    pulse_start();
    if (restart_at > 0) begin
      repeat (restart_at - 1) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (ndone != n0) break;
    end
    if (ndone == n0) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_err"}, int'(err_count), 0);
    chk({tag, "_first"}, int'(first_fail), 0);
    chk({tag, "_mask"}, int'(fail_mask), 0);
    chk({tag, "_stim"}, int'(stim), 0);
  endtask

  // Monitor: every rising done pops one expectation
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (sbq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("err_count", int'(err_count), e.err);
        chk("first_fail", int'(first_fail), e.first);
        chk("fail_mask", int'(fail_mask), int'(e.mask));
        chk("pass", int'(pass), e.pass);
        chk("busy_at_done", int'(busy), 0);
        chk("latency", int'(($time - 5 - start_t) / 10), 32);
        chk("sat_err", int'(s_err), 7);
        chk("sat_first", int'(s_first), 0);
        chk("sat_mask", int'(s_mask), 11'h7ff);
        chk("sat_pass", int'(s_pass), 0);
        chk("one_done", int'(o_done), 1);
        chk("one_pass", int'(o_pass), 1);
        chk("one_err", int'(o_err), 0);
      end
      ndone++;
    end
    done_q = done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    set_flips(0);
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    rst_n = 1'b1;

    set_flips(0); run_sweep(0);
    set_flips(1); run_sweep(0);
    set_flips(2); run_sweep(0);
    repeat (3) begin set_flips(3); run_sweep(0); end
    repeat (2) begin set_flips(4); run_sweep(0); end

    // Abort in the CHECK cycle of stim=5: vectors 0..4 counted, 5 discarded
    set_flips(1);
    pulse_start();
    repeat (11) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_stim", int'(stim), 5);
    chk("abort_err", int'(err_count), 5);
    chk("abort_first", int'(first_fail), 0);
    repeat (40) @(posedge clk);
    #1 chk("abort_no_done", int'(done), 0);
    set_flips(0); run_sweep(0);

    // Abort wins over a simultaneous start
    pulse_start();
    repeat (3) @(posedge clk);
    #1 begin abort = 1'b1; start = 1'b1; end
    @(posedge clk); #1 begin abort = 1'b0; start = 1'b0; end
    chk("abort_start_busy", int'(busy), 0);
    chk("abort_start_done", int'(done), 0);

    // Start re-pulsed at cycle 10 must not disturb the sweep
    set_flips(3); run_sweep(10);

    // Reset mid-sweep clears everything immediately
    set_flips(1);
    pulse_start();
    repeat (11) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    #2 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1 chk("midreset_no_done", int'(done), 0);

    repeat (3) @(posedge clk);
    chk("queue_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
